// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered display value.
// Define SSEG_LZB_EN to blank leading zero digits (digit 0 is always driven).
module sseg_scan_ctrl #(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    output logic [3:0]  an,
    output logic [3:0]  hex_num,
    output logic [1:0]  digit_idx,
    output logic        upd
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [1:0]       idx_nxt;
    logic             wrap;
    logic             xfer;
    logic [15:0]      disp;
    logic [15:0]      disp_nxt;
    logic [15:0]      pend;
    logic             pend_valid;

    function automatic logic [3:0] nibble_sel(input logic [15:0] d, input logic [1:0] k);
        return d[{k, 2'b00} +: 4];
    endfunction

`ifdef SSEG_LZB_EN
    function automatic logic lead_zero(input logic [15:0] d, input logic [1:0] k);
        case (k)
            2'd1:    return (d[15:4]  == 12'h000);
            2'd2:    return (d[15:8]  == 8'h00);
            2'd3:    return (d[15:12] == 4'h0);
            default: return 1'b0;
        endcase
    endfunction
`endif

    function automatic logic [3:0] anode_sel(input logic [0:0] st, input logic [1:0] k,
                                             input logic [15:0] d);
        logic [3:0] onehot;
        onehot = 4'b0001 << k;
        if (st == ST_BLANK)
            return 4'b1111;
`ifdef SSEG_LZB_EN
        if (lead_zero(d, k))
            return 4'b1111;
`endif
        return ~onehot;
    endfunction

    // Next-state values; all outputs are registered from these so they move on the same edge.
    always_comb begin
        wrap     = (cnt == CNT_LAST);
        cnt_nxt  = wrap ? '0 : cnt + CNT_W'(1);
        idx_nxt  = wrap ? digit_idx + 2'd1 : digit_idx;
        xfer     = wrap && (digit_idx == 2'd3) && pend_valid;
        disp_nxt = xfer ? pend : disp;
        case (state)
            ST_BLANK: state_nxt = (cnt_nxt == CNT_BLANK) ? ST_DRIVE : ST_BLANK;
            ST_DRIVE: state_nxt = wrap ? ST_BLANK : ST_DRIVE;
            default:  state_nxt = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            state      <= ST_BLANK;
            digit_idx  <= 2'd0;
            an         <= 4'b1111;
            hex_num    <= 4'h0;
            disp       <= 16'h0000;
            pend       <= 16'h0000;
            pend_valid <= 1'b0;
            upd        <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            state     <= state_nxt;
            digit_idx <= idx_nxt;
            disp      <= disp_nxt;
            an        <= anode_sel(state_nxt, idx_nxt, disp_nxt);
            hex_num   <= nibble_sel(disp_nxt, idx_nxt);
            upd       <= xfer;
            // A load coinciding with a transfer re-arms pend for the next frame.
            if (load) begin
                pend       <= value;
                pend_valid <= 1'b1;
            end else if (xfer) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomised and directed bench for sseg_scan_ctrl against a frame/slot arithmetic model.
module tb_sseg_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  an;
    logic [3:0]  hex_num;
    logic [1:0]  digit_idx;
    logic        upd;

    sseg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value     (value),
        .an        (an),
        .hex_num   (hex_num),
        .digit_idx (digit_idx),
        .upd       (upd)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: t counts cycles since the reset edge; slot, digit and frame follow arithmetically.
    int unsigned t = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    bit          m_pv   = 1'b0;
    bit          m_upd  = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h (t=%0d, time %0t)", tag, obs, exp, t, $time);
    endtask

    function automatic logic [3:0] exp_an();
        int pos;
        int k;
        logic [3:0] onehot;
        pos = int'(t % DIV);
        k   = int'((t / DIV) % 4);
        if (pos < BLANK)
            return 4'b1111;
`ifdef SSEG_LZB_EN
        if (k > 0 && (m_disp >> (4 * k)) == 16'h0000)
            return 4'b1111;
`endif
        onehot = 4'b0001 << k;
        return ~onehot;
    endfunction

    task automatic step(input logic r, input logic l, input logic [15:0] v);
        logic [3:0] e_an;
        int k;
        rst   = r;
        load  = l;
        value = v;
        @(posedge clk);
        if (r) begin
            t      = 0;
            m_disp = 16'h0000;
            m_pend = 16'h0000;
            m_pv   = 1'b0;
            m_upd  = 1'b0;
        end else begin
            m_upd = ((t % FRAME) == FRAME - 1) && m_pv;
            if (m_upd) begin
                m_disp = m_pend;
                m_pv   = 1'b0;
            end
            if (l) begin
                m_pend = v;
                m_pv   = 1'b1;
            end
            t++;
        end
        #1;
        e_an = exp_an();
        k    = int'((t / DIV) % 4);
        chk("an", 16'(an), 16'(e_an));
        chk("digit_idx", 16'(digit_idx), 16'(k));
        chk("upd", 16'(upd), 16'(m_upd));
        if (e_an != 4'b1111)
            chk("hex_num", 16'(hex_num), 16'(m_disp[4*k +: 4]));
        if (r)
            chk("rst_hex_num", 16'(hex_num), 16'h0000);
    endtask

    task automatic idle_to(input int unsigned ph);
        for (int i = 0; i < 2 * FRAME && (t % FRAME) != ph; i++)
            step(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0000;

        // Plain scan after reset
        step(1'b1, 1'b0, 16'h0000);
        idle(32);

        // Load during slot 1, transfer at the next frame boundary
        idle_to(9);
        step(1'b0, 1'b1, 16'h1234);
        idle(2 * FRAME);

        // Two loads in one frame: latest wins, one upd
        idle_to(3);
        step(1'b0, 1'b1, 16'hAAAA);
        idle_to(20);
        step(1'b0, 1'b1, 16'h5555);
        idle(2 * FRAME);

        // Load exactly on the frame-boundary edge with nothing pending
        idle_to(FRAME - 1);
        step(1'b0, 1'b1, 16'hBEEF);
        idle(2 * FRAME + 4);

        // Reset in cycle 5 of slot 2 with a value pending, concurrent load discarded
        idle_to(5);
        step(1'b0, 1'b1, 16'hCAFE);
        idle_to(2 * DIV + 5);
        step(1'b1, 1'b1, 16'h7777);
        idle(2 * FRAME);

        // Leading-zero patterns
        step(1'b0, 1'b1, 16'h0070);
        idle(2 * FRAME);
        step(1'b0, 1'b1, 16'h0000);
        idle(2 * FRAME);
        step(1'b0, 1'b1, 16'h0F00);
        idle(2 * FRAME);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic l;
            logic [15:0] v;
            r = ($urandom_range(0, 399) == 0);
            l = ($urandom_range(0, 15) == 0);
            v = 16'($urandom);
            step(r, l, v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 Parameter DIV, default 100000: clk cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter BLANK, default 1000: blanking cycles at the start of each slot; legal range 1..DIV-2.
REQ-003 clk  input  1  system clock; one clock; every flop on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 load  input  1  one-cycle request to capture value.
REQ-006 value  input  16  four hex nibbles; nibble 0 = value[3:0] = rightmost digit.
REQ-007 an  output  4  digit anodes, active-low, registered; an[0] = rightmost digit.
REQ-008 hex_num  output  4  nibble for the active digit, registered; feeds the segment decoder.
REQ-009 digit_idx  output  2  index of the current slot, registered.
REQ-010 upd  output  1  one-cycle pulse: display register updated.

Function
REQ-011 Slot counter cnt SHALL count 0..DIV-1, then wrap to 0.
REQ-012 The FSM SHALL have two states: BLANK (cnt < BLANK) and DRIVE (BLANK <= cnt <= DIV-1).
- BLANK->DRIVE when cnt reaches BLANK.
- DRIVE->BLANK on cnt wrap.
REQ-013 In BLANK, an SHALL be 4'b1111.
REQ-014 In DRIVE, an SHALL drive exactly bit digit_idx low.
REQ-015 On cnt wrap, digit_idx SHALL advance 0->1->2->3->0.
REQ-016 hex_num SHALL equal disp[4*digit_idx+3 -: 4] and SHALL be valid whenever an is not all-ones.
REQ-017 Outputs SHALL be registered and SHALL change on the same edge as the state/index change; there is no extra pipeline cycle.
REQ-018 load=1 SHALL write value into pend and set pend_valid in the same edge.
REQ-019 load while pend_valid=1 SHALL overwrite pend; the latest value wins.
REQ-020 Frame boundary is the wrap with digit_idx 3->0. At a frame boundary with pend_valid=1:
- disp <= pend;
- pend_valid <= 0;
- upd = 1 for exactly one cycle.
REQ-021 disp SHALL change only at a frame boundary, so there is no tearing within a frame.
REQ-022 load on the same cycle as a frame boundary:
- transfer uses the pre-edge pend (only if pend_valid was 1);
- the new value lands in pend with pend_valid=1 and transfers at the next boundary.
REQ-023 Frame boundary with pend_valid=0: disp is unchanged and upd stays 0.

Reset
REQ-024 rst=1 at an edge SHALL set: cnt=0, state=BLANK, digit_idx=0, an=4'b1111, hex_num=0, disp=0, pend=0, pend_valid=0, upd=0.
REQ-025 rst SHALL override a concurrent load; that value is discarded.
REQ-026 Reset mid-slot SHALL abort the slot; scanning restarts at digit 0, BLANK, on the first edge after rst deasserts.

Configuration
REQ-027 Macro SSEG_LZB_EN SHALL enable leading-zero blanking:
- In DRIVE, digit k (k>0) SHALL keep an=4'b1111 when disp nibbles k..3 are all zero.
- Digit 0 SHALL always be driven.
- Slot timing and digit_idx SHALL be unaffected.
REQ-028 Without SSEG_LZB_EN, all four digits SHALL be driven in every DRIVE phase.

Verification
Bench uses DIV=8, BLANK=2.
REQ-029 Reset, then run 32 cycles. Required:
- an = 1111 on cycles 0-1 of each slot;
- an = 1110, 1101, 1011, 0111 on cycles 2-7 of successive slots;
- digit_idx sequence 0,1,2,3;
- hex_num=0.
REQ-030 load value=16'h1234 in slot 1. Required:
- disp unchanged until the 3->0 wrap;
- then upd pulses once;
- the next frame shows hex_num 4,3,2,1.
REQ-031 load 16'hAAAA, then load 16'h5555 within the same frame. Required: only 16'h5555 is displayed, and a single upd pulse.
REQ-032 load 16'hBEEF on the exact frame-boundary cycle with pend_valid=0. Required: no upd at that boundary; upd and BEEF at the following boundary.
REQ-033 Assert rst in cycle 5 of slot 2 while pend_valid=1. Required:
- next edge: an = 1111, digit_idx = 0, disp = 0, pend_valid = 0;
- scanning resumes from digit 0.
REQ-034 With SSEG_LZB_EN defined and disp=16'h0070. Required:
- digits 2 and 3 stay 1111 during DRIVE;
- digits 0 and 1 are driven;
- with disp=0, only digit 0 is driven, showing 0.
